// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: drives the PC register, issues single-outstanding
// imem requests and buffers one fetched instruction for decode.
module if_fetch_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_step_in,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_err
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; valid never depends on ready, and data is held stable while valid waits.

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_ERR} state_t;

  localparam bit              TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

  state_t            state, state_nxt;
  logic              kill, kill_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [XLEN-1:0]   req_pc, req_pc_nxt;
  logic              id_valid_nxt;
  logic [XLEN-1:0]   id_instr_nxt, id_pc_nxt;
  logic              fetch_err_nxt;

  assign imem_addr = pc_in;
  assign cnt_inc   = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      kill      <= 1'b0;
      cnt       <= '0;
      req_pc    <= '0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      kill      <= kill_nxt;
      cnt       <= cnt_nxt;
      req_pc    <= req_pc_nxt;
      id_valid  <= id_valid_nxt;
      id_instr  <= id_instr_nxt;
      id_pc     <= id_pc_nxt;
      fetch_err <= fetch_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    kill_nxt       = kill;
    cnt_nxt        = cnt;
    req_pc_nxt     = req_pc;
    id_valid_nxt   = id_valid;
    id_instr_nxt   = id_instr;
    id_pc_nxt      = id_pc;
    fetch_err_nxt  = fetch_err;
    imem_req_valid = 1'b0;
    pc_write       = 1'b0;
    next_pc        = pc_step_in;

    case (state)
      S_REQ: begin
        imem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_write = 1'b1;
          next_pc  = redirect_pc;
        end else if (imem_req_ready) begin
          pc_write   = 1'b1;
          req_pc_nxt = pc_in;
          cnt_nxt    = '0;
          state_nxt  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_write = 1'b1;
          next_pc  = redirect_pc;
        end
        if (imem_rsp_valid) begin
          kill_nxt = 1'b0;
          // A redirect now or earlier makes this response belong to a dead path.
          if (redirect_valid || kill) begin
            state_nxt = S_REQ;
          end else begin
            id_instr_nxt = imem_rsp_data;
            id_pc_nxt    = req_pc;
            id_valid_nxt = 1'b1;
            state_nxt    = S_OUT;
          end
        end else begin
          cnt_nxt = cnt_inc;
          if (redirect_valid) kill_nxt = 1'b1;
          if (TO_EN && (cnt_inc == TO_LIM)) begin
            fetch_err_nxt = 1'b1;
            state_nxt     = S_ERR;
          end
        end
      end

      S_OUT: begin
        if (redirect_valid) begin
          pc_write     = 1'b1;
          next_pc      = redirect_pc;
          id_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end else if (id_ready) begin
          id_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end
      end

      S_ERR: begin
        fetch_err_nxt = 1'b1;
      end

      default: state_nxt = S_REQ;
    endcase

    if (rst) pc_write = 1'b0;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a cycle table of pin-level stimulus with
// hand-computed outputs, then backpressure, timeout and reset sequences.
module tb_if_fetch_ctrl;

  localparam int XLEN = 32;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [31:0] I0  = 32'hC0DE_0000;
  localparam logic [31:0] I1  = 32'hC0DE_0001;
  localparam logic [31:0] I2  = 32'hC0DE_0002;
  localparam logic [31:0] I20 = 32'hC0DE_0020;
  localparam logic [31:0] I21 = 32'hC0DE_0021;
  localparam logic [31:0] I40 = 32'hC0DE_0040;
  localparam logic [31:0] I80 = 32'hC0DE_0080;
  localparam logic [31:0] Z   = 32'h0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [XLEN-1:0] pc_in, pc_step_in, next_pc, redirect_pc, imem_addr;
  logic [XLEN-1:0] imem_rsp_data, id_instr, id_pc;
  logic pc_write, redirect_valid, imem_req_valid, imem_req_ready;
  logic imem_rsp_valid, id_valid, id_ready, fetch_err;

  if_fetch_ctrl #(.XLEN(XLEN), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .pc_step_in(pc_step_in),
    .next_pc(next_pc), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic [31:0] pc, step;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy, rspv;
    logic [31:0] rspd;
    logic        idr;
    logic [31:0] npc;
    logic        pw, reqv, idv;
    logic [31:0] idi, idpc;
    logic        err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(
    input logic [31:0] pc, step, input logic rv, input logic [31:0] rpc,
    input logic rdy, rspv, input logic [31:0] rspd, input logic idr,
    input logic [31:0] npc, input logic pw, reqv, idv,
    input logic [31:0] idi, idpc, input logic err);
    vec_t v;
    v.pc = pc; v.step = step; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.rspv = rspv; v.rspd = rspd; v.idr = idr; v.npc = npc; v.pw = pw;
    v.reqv = reqv; v.idv = idv; v.idi = idi; v.idpc = idpc; v.err = err;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: inputs at negedge, outputs sampled 1ns later, before the next posedge
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    pc_in = v.pc; pc_step_in = v.step;
    redirect_valid = v.rv; redirect_pc = v.rpc;
    imem_req_ready = v.rdy; imem_rsp_valid = v.rspv; imem_rsp_data = v.rspd;
    id_ready = v.idr;
    #1;
    chk({tag, ".next_pc"}, next_pc, v.npc);
    chk({tag, ".pc_write"}, {31'b0, pc_write}, {31'b0, v.pw});
    chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.reqv});
    chk({tag, ".imem_addr"}, imem_addr, v.pc);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, v.idv});
    chk({tag, ".fetch_err"}, {31'b0, fetch_err}, {31'b0, v.err});
    if (v.idv) begin
      chk({tag, ".id_instr"}, id_instr, v.idi);
      chk({tag, ".id_pc"}, id_pc, v.idpc);
    end
  endtask

  task automatic idle_inputs();
    pc_in = 32'h0; pc_step_in = 32'h1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    id_ready = 1'b0;
  endtask

  vec_t tbl[25];

  initial begin
    //        pc     step   rv  rpc    rdy rspv rspd     idr   npc    pw reqv idv idi  idpc   err
    tbl[0]  = mk(0,     1,     N, 0,     Y, N, Z,       Y,    1,     Y, Y, N, Z,   0,     N);
    tbl[1]  = mk(1,     2,     N, 0,     N, Y, I0,      N,    2,     N, N, N, Z,   0,     N);
    tbl[2]  = mk(1,     2,     N, 0,     N, N, Z,       Y,    2,     N, N, Y, I0,  0,     N);
    tbl[3]  = mk(1,     2,     N, 0,     Y, N, Z,       N,    2,     Y, Y, N, Z,   0,     N);
    tbl[4]  = mk(2,     3,     N, 0,     N, Y, I1,      N,    3,     N, N, N, Z,   0,     N);
    tbl[5]  = mk(2,     3,     N, 0,     N, N, Z,       Y,    3,     N, N, Y, I1,  1,     N);
    tbl[6]  = mk(2,     3,     N, 0,     Y, N, Z,       N,    3,     Y, Y, N, Z,   0,     N);
    tbl[7]  = mk(3,     4,     N, 0,     N, Y, I2,      N,    4,     N, N, N, Z,   0,     N);
    tbl[8]  = mk(3,     4,     N, 0,     N, N, Z,       Y,    4,     N, N, Y, I2,  2,     N);
    // redirect in S_REQ with memory ready: no request, PC loads target
    tbl[9]  = mk(3,     4,     Y, 4,     Y, N, Z,       N,    4,     Y, N, N, Z,   0,     N);
    tbl[10] = mk(4,     5,     N, 0,     Y, N, Z,       N,    5,     Y, Y, N, Z,   0,     N);
    // redirect in S_WAIT, stale response for pc 4 then dropped
    tbl[11] = mk(5,     6,     Y, 'h40,  N, N, Z,       N,    'h40,  Y, N, N, Z,   0,     N);
    tbl[12] = mk('h40,  'h41,  N, 0,     N, Y, 'hBAD4,  N,    'h41,  N, N, N, Z,   0,     N);
    tbl[13] = mk('h40,  'h41,  N, 0,     N, N, Z,       N,    'h41,  N, Y, N, Z,   0,     N);
    tbl[14] = mk('h40,  'h41,  N, 0,     Y, N, Z,       N,    'h41,  Y, Y, N, Z,   0,     N);
    tbl[15] = mk('h41,  'h42,  N, 0,     N, Y, I40,     N,    'h42,  N, N, N, Z,   0,     N);
    // redirect in S_OUT beats id_ready
    tbl[16] = mk('h41,  'h42,  Y, 'h80,  N, N, Z,       Y,    'h80,  Y, N, Y, I40, 'h40,  N);
    tbl[17] = mk('h80,  'h81,  N, 0,     N, N, Z,       N,    'h81,  N, Y, N, Z,   0,     N);
    tbl[18] = mk('h80,  'h81,  N, 0,     Y, N, Z,       N,    'h81,  Y, Y, N, Z,   0,     N);
    // redirect coincident with response
    tbl[19] = mk('h81,  'h82,  Y, 'h20,  N, Y, I80,     N,    'h20,  Y, N, N, Z,   0,     N);
    tbl[20] = mk('h20,  'h21,  N, 0,     N, N, Z,       N,    'h21,  N, Y, N, Z,   0,     N);
    // response outside S_WAIT is ignored
    tbl[21] = mk('h20,  'h21,  N, 0,     N, Y, 'hBAD,   N,    'h21,  N, Y, N, Z,   0,     N);
    tbl[22] = mk('h20,  'h21,  N, 0,     Y, N, Z,       N,    'h21,  Y, Y, N, Z,   0,     N);
    tbl[23] = mk('h21,  'h22,  N, 0,     N, Y, I20,     N,    'h22,  N, N, N, Z,   0,     N);
    tbl[24] = mk('h21,  'h22,  N, 0,     N, N, Z,       Y,    'h22,  N, N, Y, I20, 'h20,  N);

    // reset: redirect held high must not produce pc_write
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = 32'h99; imem_req_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst.pc_write", {31'b0, pc_write}, 32'h0);
    @(negedge clk); #1;
    chk("rst.pc_write2", {31'b0, pc_write}, 32'h0);
    chk("rst.id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst.fetch_err", {31'b0, fetch_err}, 32'h0);
    chk("rst.id_instr", id_instr, 32'h0);
    chk("rst.id_pc", id_pc, 32'h0);
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // backpressure: 5 cycles of id_ready=0 with memory ready
    apply(mk('h21, 'h22, N, 0, Y, N, Z, N, 'h22, Y, Y, N, Z, 0, N), "bp.req");
    apply(mk('h22, 'h23, N, 0, N, Y, I21, N, 'h23, N, N, N, Z, 0, N), "bp.rsp");
    for (int i = 0; i < 5; i++)
      apply(mk('h22, 'h23, N, 0, Y, N, Z, N, 'h23, N, N, Y, I21, 'h21, N),
            $sformatf("bp.hold%0d", i));
    apply(mk('h22, 'h23, N, 0, N, N, Z, Y, 'h23, N, N, Y, I21, 'h21, N), "bp.take");

    // timeout after 4 cycles in S_WAIT
    apply(mk('h22, 'h23, N, 0, Y, N, Z, N, 'h23, Y, Y, N, Z, 0, N), "to.req");
    for (int i = 0; i < 4; i++)
      apply(mk('h23, 'h24, N, 0, N, N, Z, N, 'h24, N, N, N, Z, 0, N),
            $sformatf("to.wait%0d", i));
    for (int i = 0; i < 3; i++)
      apply(mk('h23, 'h24, Y, 'h99, Y, Y, I80, Y, 'h24, N, N, N, Z, 0, Y),
            $sformatf("to.err%0d", i));

    // reset out of S_ERR, then fetch restarts at pc 0
    @(negedge clk);
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = 32'h99;
    rst = 1'b1;
    #1;
    chk("rst2.pc_write", {31'b0, pc_write}, 32'h0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rst2.fetch_err", {31'b0, fetch_err}, 32'h0);
    chk("rst2.req_valid", {31'b0, imem_req_valid}, 32'h1);
    apply(mk(0, 1, N, 0, Y, N, Z, N, 1, Y, Y, N, Z, 0, N), "rst2.req");
    apply(mk(1, 2, N, 0, N, Y, I0, N, 2, N, N, N, Z, 0, N), "rst2.rsp");
    apply(mk(1, 2, N, 0, N, N, Z, Y, 2, N, N, Y, I0, 0, N), "rst2.out");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
